// File: rtl/sale_terminal_pkg.sv
// Shared definitions for the sale terminal LED display: mode encoding,
// fixed LED patterns and a small pattern helper.
package sale_terminal_pkg;

  localparam int LED_W = 10;

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_ERROR  = 2'b01,
    MODE_DONE   = 2'b10
  } mode_t;

  localparam logic [LED_W-1:0] LED_ALL_ON      = 10'h3FF;
  localparam logic [LED_W-1:0] LED_CHASE_START = 10'h001;

  // Rotate the chase pattern one place left, bit 9 wrapping to bit 0.
  function automatic logic [LED_W-1:0] rotl_led(input logic [LED_W-1:0] v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler: ms_tick is high for one clock out of
// every CLK_HZ/1000. Only the asynchronous reset ever clears the count.
module ms_tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign ms_tick = (cnt == LAST);

endmodule

// File: rtl/led_sequencer.sv
// LED display sequencer: passes the normal status view through, or shows a
// blinking ERROR pattern / a chasing DONE pattern for a hold time. ERROR wins
// over DONE; a DONE request seen during ERROR is remembered and played after.
module led_sequencer
  import sale_terminal_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_MS = 250,
  parameter int STEP_MS  = 100,
  parameter int HOLD_MS  = 2000
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [9:0]  norm_leds,
  input  logic        err_req,
  input  logic        done_req,
  input  logic        clr,
  output logic [9:0]  LEDR,
  output logic [1:0]  mode,
  output logic        busy
);

  localparam int PMAX = (BLINK_MS > STEP_MS) ? BLINK_MS : STEP_MS;
  localparam int TW   = $clog2(PMAX + 1);
  localparam int HW   = $clog2(HOLD_MS + 1);

  localparam logic [HW-1:0] HOLD_LD    = HW'(HOLD_MS);
  localparam logic [TW-1:0] BLINK_LAST = TW'(BLINK_MS - 1);
  localparam logic [TW-1:0] STEP_LAST  = TW'(STEP_MS - 1);

  logic          ms_tick;
  mode_t         state, state_nx;
  logic          pending, pending_nx;
  logic [HW-1:0] hold, hold_nx;
  logic [TW-1:0] ptimer, ptimer_nx;
  logic [9:0]    led_nx;
  logic          busy_nx;
  logic          hold_last, blink_due, step_due;

  ms_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick (
    .clk     (CLOCK_50),
    .rst_n   (RESET_N),
    .ms_tick (ms_tick)
  );

  assign hold_last = (hold == HW'(1));
  assign blink_due = (ptimer == BLINK_LAST);
  assign step_due  = (ptimer == STEP_LAST);

  // Next state, pattern timers and next LED pattern.
  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    hold_nx    = hold;
    ptimer_nx  = ptimer;
    led_nx     = LEDR;

    if (clr) begin
      state_nx   = MODE_NORMAL;
      pending_nx = 1'b0;
      hold_nx    = '0;
      ptimer_nx  = '0;
      led_nx     = norm_leds;
    end else begin
      case (state)
        MODE_NORMAL: begin
          if (err_req) begin
            state_nx   = MODE_ERROR;
            pending_nx = done_req;
            hold_nx    = HOLD_LD;
            ptimer_nx  = '0;
            led_nx     = LED_ALL_ON;
          end else if (done_req) begin
            state_nx  = MODE_DONE;
            hold_nx   = HOLD_LD;
            ptimer_nx = '0;
            led_nx    = LED_CHASE_START;
          end else begin
            led_nx = norm_leds;
          end
        end

        MODE_ERROR: begin
          pending_nx = pending | done_req;
          if (ms_tick) begin
            hold_nx = hold - 1'b1;
            if (blink_due) begin
              ptimer_nx = '0;
              led_nx    = ~LEDR;
            end else begin
              ptimer_nx = ptimer + 1'b1;
            end
          end
          // A repeated error request extends the display but keeps the blink phase.
          if (err_req) begin
            hold_nx = HOLD_LD;
          end else if (ms_tick && hold_last) begin
            if (pending_nx) begin
              state_nx   = MODE_DONE;
              pending_nx = 1'b0;
              hold_nx    = HOLD_LD;
              ptimer_nx  = '0;
              led_nx     = LED_CHASE_START;
            end else begin
              state_nx  = MODE_NORMAL;
              hold_nx   = '0;
              ptimer_nx = '0;
              led_nx    = norm_leds;
            end
          end
        end

        MODE_DONE: begin
          if (err_req) begin
            state_nx   = MODE_ERROR;
            pending_nx = done_req;
            hold_nx    = HOLD_LD;
            ptimer_nx  = '0;
            led_nx     = LED_ALL_ON;
          end else begin
            if (ms_tick) begin
              hold_nx = hold - 1'b1;
              if (step_due) begin
                ptimer_nx = '0;
                led_nx    = rotl_led(LEDR);
              end else begin
                ptimer_nx = ptimer + 1'b1;
              end
            end
            // A repeated done request extends the display and keeps the chase position.
            if (done_req) begin
              hold_nx = HOLD_LD;
            end else if (ms_tick && hold_last) begin
              state_nx  = MODE_NORMAL;
              hold_nx   = '0;
              ptimer_nx = '0;
              led_nx    = norm_leds;
            end
          end
        end

        default: begin
          state_nx   = MODE_NORMAL;
          pending_nx = 1'b0;
          hold_nx    = '0;
          ptimer_nx  = '0;
          led_nx     = norm_leds;
        end
      endcase
    end

    busy_nx = (state_nx != MODE_NORMAL) || pending_nx;
  end

  // State, counters and all outputs are registered.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= MODE_NORMAL;
      pending <= 1'b0;
      hold    <= '0;
      ptimer  <= '0;
      LEDR    <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      hold    <= hold_nx;
      ptimer  <= ptimer_nx;
      LEDR    <= led_nx;
      busy    <= busy_nx;
    end
  end

  assign mode = state;

endmodule
